// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a pending-write
// scoreboard that raises STALL on read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  output logic              ISSUE_READY,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [ADDR_W-1:0] R2_ADDR,
  input  logic [ADDR_W-1:0] RD_ADDR,
  input  logic              R1_USE,
  input  logic              R2_USE,
  input  logic              RD_USE,
  output logic              STALL,
  output logic              W_ENABLE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic [NREG-1:0]   PENDING,
  output logic              ORPHAN_ERR
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic            last_b;
  logic            grant;
  wr_req_t         req_sel;
  logic [NREG-1:0] pending_nxt;

  // last_b=1 means B had the most recent grant, so A wins the next tie.
  assign A_READY     = rst & A_VALID & (~B_VALID | last_b);
  assign B_READY     = rst & B_VALID & (~A_VALID | ~last_b);
  assign grant       = A_READY | B_READY;
  assign req_sel     = A_READY ? '{addr: A_ADDR, data: A_DATA}
                               : '{addr: B_ADDR, data: B_DATA};
  assign ISSUE_READY = rst & ISSUE_VALID & ~PENDING[ISSUE_ADDR];

  assign STALL = (R1_USE & PENDING[R1_ADDR]) |
                 (R2_USE & PENDING[R2_ADDR]) |
                 (RD_USE & PENDING[RD_ADDR]);

  // Clear first, then set, so a same-edge reservation survives the commit.
  always_comb begin
    pending_nxt = PENDING;
    if (W_ENABLE)    pending_nxt[W_ADDR]     = 1'b0;
    if (ISSUE_READY) pending_nxt[ISSUE_ADDR] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      W_ENABLE   <= 1'b0;
      W_ADDR     <= '0;
      W_DATA     <= '0;
      PENDING    <= '0;
      ORPHAN_ERR <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      W_ENABLE <= grant;
      if (grant) begin
        W_ADDR <= req_sel.addr;
        W_DATA <= req_sel.data;
        last_b <= B_READY;
      end
      PENDING <= pending_nxt;
      // Commit with no reservation is flagged but still written.
      if (W_ENABLE && !PENDING[W_ADDR]) ORPHAN_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed plan steps followed by a random phase,
// all checked against a transaction-level model of writes and reservations.
module tb_regfile_wb_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_valid, b_valid, issue_valid;
  logic [AW-1:0] a_addr, b_addr, issue_addr, r1_addr, r2_addr, rd_addr;
  logic [DW-1:0] a_data, b_data;
  logic          r1_use, r2_use, rd_use;
  logic          a_ready, b_ready, issue_ready, stall, w_enable, orphan_err;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [NR-1:0] pending;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .rst(rst),
    .A_VALID(a_valid), .A_ADDR(a_addr), .A_DATA(a_data), .A_READY(a_ready),
    .B_VALID(b_valid), .B_ADDR(b_addr), .B_DATA(b_data), .B_READY(b_ready),
    .ISSUE_VALID(issue_valid), .ISSUE_ADDR(issue_addr), .ISSUE_READY(issue_ready),
    .R1_ADDR(r1_addr), .R2_ADDR(r2_addr), .RD_ADDR(rd_addr),
    .R1_USE(r1_use), .R2_USE(r2_use), .RD_USE(rd_use),
    .STALL(stall), .W_ENABLE(w_enable), .W_ADDR(w_addr), .W_DATA(w_data),
    .PENDING(pending), .ORPHAN_ERR(orphan_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: set of reserved registers, who was served last, the one write in
  // flight toward the register file, and the resulting register contents.
  bit m_pend[NR];
  bit m_last_a;
  bit m_we;
  int m_waddr, m_wdata;
  bit m_orphan;
  int m_rf[NR];
  int d_rf[NR];          // register file as written by the DUT's write port
  bit a_acc, b_acc, i_acc;
  bit d_a, d_b, d_i, d_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit ea, eb, ei, es;
    logic [NR-1:0] p;
    @(negedge clk);
    ea = rst && a_valid && (!b_valid || !m_last_a);
    eb = rst && b_valid && (!a_valid || m_last_a);
    ei = rst && issue_valid && !m_pend[issue_addr];
    es = (r1_use && m_pend[r1_addr]) || (r2_use && m_pend[r2_addr]) ||
         (rd_use && m_pend[rd_addr]);
    d_a = a_ready; d_b = b_ready; d_i = issue_ready; d_stall = stall;
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("issue_ready", issue_ready, ei);
    chk("stall", stall, es);
    if (rst && w_enable === 1'b1) d_rf[w_addr] = w_data;
    @(posedge clk);
    if (!rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_last_a = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_orphan = 0;
    end else begin
      if (m_we) begin
        m_rf[m_waddr] = m_wdata;
        if (!m_pend[m_waddr]) m_orphan = 1;
        m_pend[m_waddr] = 0;
      end
      if (ei) m_pend[issue_addr] = 1;
      m_we = ea || eb;
      if (ea) begin m_waddr = a_addr; m_wdata = a_data; m_last_a = 1; end
      else if (eb) begin m_waddr = b_addr; m_wdata = b_data; m_last_a = 0; end
    end
    a_acc = ea; b_acc = eb; i_acc = ei;
    #1;
    for (int i = 0; i < NR; i++) p[i] = m_pend[i];
    chk("w_enable", w_enable, m_we);
    chk("w_addr", w_addr, m_waddr);
    chk("w_data", w_data, m_wdata);
    chk("pending", pending, p);
    chk("orphan_err", orphan_err, m_orphan);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (a_valid || b_valid); i++) begin
      cycle();
      if (a_acc) a_valid = 0;
      if (b_acc) b_valid = 0;
    end
    chk("drain_done", {a_valid, b_valid}, 2'b00);
  endtask

  initial begin
    foreach (m_rf[i]) begin m_rf[i] = 0; d_rf[i] = 0; end
    m_last_a = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_orphan = 0;
    a_valid = 0; b_valid = 0; issue_valid = 0;
    a_addr = 0; b_addr = 0; issue_addr = 0; a_data = 0; b_data = 0;
    r1_addr = 0; r2_addr = 0; rd_addr = 0; r1_use = 0; r2_use = 0; rd_use = 0;
    #1;
    do_reset(2);
    chk("rst_pending", pending, 8'h00);
    chk("rst_wen", w_enable, 1'b0);

    // Reserve r3, A writes r3=0x5A.
    issue_valid = 1; issue_addr = 3; cycle(); issue_valid = 0;
    chk("t1_pend_set", pending, 8'h08);
    a_valid = 1; a_addr = 3; a_data = 8'h5A; cycle(); a_valid = 0;
    chk("t1_wen", w_enable, 1'b1);
    chk("t1_wdata", {w_addr, w_data}, {3'd3, 8'h5A});
    cycle();
    chk("t1_pend_clr", pending, 8'h00);
    chk("t1_rf", d_rf[3], 32'h5A);

    // Contention after reset: A, B, A, B with W_ENABLE held.
    do_reset(1);
    a_valid = 1; a_addr = 1; a_data = 8'h11;
    b_valid = 1; b_addr = 2; b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("cont_order", {d_a, d_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("cont_wen", w_enable, 1'b1);
    end
    a_valid = 0; b_valid = 0; cycle();

    // Same-register race on r5.
    do_reset(1);
    issue_valid = 1; issue_addr = 5; cycle(); issue_valid = 0;
    a_valid = 1; a_addr = 5; a_data = 8'h01;
    b_valid = 1; b_addr = 5; b_data = 8'h02;
    drain();
    cycle(); cycle();
    chk("race_rf5", d_rf[5], 32'h02);
    chk("race_orphan", orphan_err, 1'b1);

    // Hazard on r6 via R1.
    do_reset(1);
    r1_addr = 6; r1_use = 1;
    issue_valid = 1; issue_addr = 6; cycle(); issue_valid = 0;
    cycle(); chk("haz_stall_on", d_stall, 1'b1);
    a_valid = 1; a_addr = 6; a_data = 8'h66; cycle(); a_valid = 0;
    chk("haz_stall_grant", d_stall, 1'b1);
    cycle(); chk("haz_stall_commit", d_stall, 1'b1);
    cycle(); chk("haz_stall_off", d_stall, 1'b0);
    r1_use = 0;
    issue_valid = 1; issue_addr = 6; cycle(); issue_valid = 0;
    cycle(); chk("haz_nouse", d_stall, 1'b0);
    a_valid = 1; drain(); cycle(); cycle();

    // WAW on r4, then reservation on the same edge as an orphan commit.
    do_reset(1);
    issue_valid = 1; issue_addr = 4; cycle();
    cycle(); issue_valid = 0;
    chk("waw_second", d_i, 1'b0);
    a_valid = 1; a_addr = 4; a_data = 8'h44; cycle(); a_valid = 0;
    cycle(); cycle();
    chk("waw_pend_clr", pending[4], 1'b0);
    a_valid = 1; a_addr = 4; a_data = 8'h45; cycle(); a_valid = 0;
    issue_valid = 1; issue_addr = 4; cycle(); issue_valid = 0;
    chk("overlap_set_wins", pending[4], 1'b1);
    chk("overlap_orphan", orphan_err, 1'b1);

    // Reset while a write is in flight: the write is dropped.
    do_reset(1);
    a_valid = 1; a_addr = 7; a_data = 8'hFF; cycle(); a_valid = 0;
    rst = 0; cycle(); rst = 1;
    chk("midrst_wen", w_enable, 1'b0);
    chk("midrst_pend", pending, 8'h00);
    cycle();
    chk("midrst_rf7", d_rf[7], 32'h0);

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1; a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1; b_addr = AW'($urandom); b_data = DW'($urandom);
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr = AW'($urandom);
      {r1_addr, r2_addr, rd_addr} = 9'($urandom);
      {r1_use, r2_use, rd_use} = 3'($urandom);
      rst = ($urandom_range(0, 63) != 0);
      cycle();
      if (a_acc) a_valid = 0;
      if (b_acc) b_valid = 0;
    end
    rst = 1; a_valid = 0; b_valid = 0; issue_valid = 0;
    cycle(); cycle();
    for (int i = 0; i < NR; i++) chk("final_rf", d_rf[i], m_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
